// File: rtl/muldiv_pkg.sv
// Shared types and op-class helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_div(input op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    // MUL low half is sign-agnostic, so it is treated as unsigned here.
    function automatic logic is_signed_op1(input op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_op2(input op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_high(input op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_rem(input op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue / writeback bundle of the multiply/divide unit.
//
// Handshake: a transfer on either channel happens on the rising edge where
// its valid and ready are both 1. The issue side may hold issue_valid until it
// sees issue_ready; the unit holds wb_valid and every wb_* field stable until
// wb_ready. rob_flush overrides both handshakes in the cycle it is high.
interface muldiv_if #(
    parameter int XLEN    = 32,
    parameter int ROBID_W = 7,
    parameter int RD_W    = 6
);
    import muldiv_pkg::*;

    logic               issue_valid;
    logic               issue_ready;
    op_t                issue_op;
    logic [ROBID_W-1:0] issue_robid;
    logic [RD_W-1:0]    issue_rd;
    logic [XLEN-1:0]    issue_op1;
    logic [XLEN-1:0]    issue_op2;
    logic               wb_valid;
    logic               wb_ready;
    logic [ROBID_W-1:0] wb_robid;
    logic [RD_W-1:0]    wb_rd;
    logic [XLEN-1:0]    wb_result;
    logic               rob_flush;
    state_t             dbg_state;

    modport master (
        output issue_valid, issue_op, issue_robid, issue_rd, issue_op1, issue_op2,
        output wb_ready, rob_flush,
        input  issue_ready, wb_valid, wb_robid, wb_rd, wb_result, dbg_state
    );

    modport slave (
        input  issue_valid, issue_op, issue_robid, issue_rd, issue_op1, issue_op2,
        input  wb_ready, rob_flush,
        output issue_ready, wb_valid, wb_robid, wb_rd, wb_result, dbg_state
    );

endinterface

// File: rtl/muldiv_booth_r4_pp.sv
// Radix-4 Booth partial product: digit in {-2..+2} times the multiplicand,
// modulo 2^W (the multiplicand arrives already sign/zero extended to W bits).
module booth_r4_pp #(
    parameter int W = 64
) (
    input  logic [2:0]   digit,
    input  logic [W-1:0] mcand,
    output logic [W-1:0] pp
);

    // Select 0, +-M or +-2M from the Booth triplet.
    always_comb begin
        pp = '0;
        case (digit)
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-4 Booth multiplier (XLEN/2+1 steps)
// and restoring magnitude divider (XLEN steps) behind one issue/writeback pair.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ROBID_W = 7,
    parameter int RD_W    = 6
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);

    localparam int              CNT_W      = $clog2(XLEN + 2);
    localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(XLEN / 2);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;

    // Latched request
    op_t                op_q;
    logic [ROBID_W-1:0] robid_q;
    logic [RD_W-1:0]    rd_q;
    logic [XLEN-1:0]    src1_q;
    logic [XLEN-1:0]    res_q;

    // Multiplier datapath: multiplier carries an implicit bit -1 at [0]
    logic [2*XLEN-1:0]  acc_q, mcand_q, pp, acc_sum;
    logic [XLEN+2:0]    mq_q;
    logic [XLEN-1:0]    mul_res;

    // Divider datapath: dq_q shifts dividend out and quotient in
    logic [XLEN-1:0]    dq_q, dr_q, dd_q;
    logic               q_neg_q, r_neg_q, div_zero_q, div_ovf_q;
    logic [XLEN:0]      r_shift, r_diff;
    logic [XLEN-1:0]    quot, rem, div_res;
    logic               div_special;

    // Issue-side decode
    logic               iss_s1, iss_s2, op1_neg, op2_neg;
    logic [XLEN-1:0]    op1_mag, op2_mag;

    assign bus.issue_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.wb_ready);
    assign accept          = bus.issue_valid && bus.issue_ready && !bus.rob_flush;
    assign bus.wb_valid    = (state_q == ST_DONE);
    assign bus.wb_robid    = robid_q;
    assign bus.wb_rd       = rd_q;
    assign bus.wb_result   = res_q;
    assign bus.dbg_state   = state_q;

    // Operand signedness and magnitudes of the incoming request.
    always_comb begin
        iss_s1  = is_signed_op1(bus.issue_op);
        iss_s2  = is_signed_op2(bus.issue_op);
        op1_neg = iss_s1 && bus.issue_op1[XLEN-1];
        op2_neg = iss_s2 && bus.issue_op2[XLEN-1];
        op1_mag = op1_neg ? -bus.issue_op1 : bus.issue_op1;
        op2_mag = op2_neg ? -bus.issue_op2 : bus.issue_op2;
    end

    // Next state: flush beats everything, including a DONE handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_div(bus.issue_op) ? ST_DIV : ST_MUL;
            ST_MUL:  if (cnt_q == MUL_LAST) state_d = ST_DONE;
            ST_DIV:  if (div_special || (cnt_q == DIV_LAST)) state_d = ST_DONE;
            ST_DONE: begin
                if (bus.wb_ready) begin
                    if (accept) state_d = is_div(bus.issue_op) ? ST_DIV : ST_MUL;
                    else        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.rob_flush) state_d = ST_IDLE;
    end

    // State register and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept || bus.rob_flush)
                cnt_q <= '0;
            else if ((state_q == ST_MUL) || (state_q == ST_DIV))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    booth_r4_pp #(.W(2 * XLEN)) u_pp (
        .digit (mq_q[2:0]),
        .mcand (mcand_q),
        .pp    (pp)
    );

    // One multiply step, one divide step, and the final result selects.
    always_comb begin
        acc_sum     = acc_q + pp;
        mul_res     = is_high(op_q) ? acc_sum[2*XLEN-1:XLEN] : acc_sum[XLEN-1:0];
        r_shift     = {dr_q, dq_q[XLEN-1]};
        r_diff      = r_shift - {1'b0, dd_q};
        div_special = div_zero_q || div_ovf_q;
        quot        = q_neg_q ? -dq_q : dq_q;
        rem         = r_neg_q ? -dr_q : dr_q;
        div_res     = is_rem(op_q) ? rem : quot;
        if (div_zero_q)
            div_res = is_rem(op_q) ? src1_q : '1;
        else if (div_ovf_q)
            div_res = is_rem(op_q) ? '0 : src1_q;
    end

    // Datapath: load on accept, iterate in MUL/DIV, capture result into DONE.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q       <= bus.issue_op;
            robid_q    <= bus.issue_robid;
            rd_q       <= bus.issue_rd;
            src1_q     <= bus.issue_op1;
            acc_q      <= '0;
            mcand_q    <= {{XLEN{op1_neg}}, bus.issue_op1};
            mq_q       <= {{2{iss_s2 && bus.issue_op2[XLEN-1]}}, bus.issue_op2, 1'b0};
            dq_q       <= op1_mag;
            dr_q       <= '0;
            dd_q       <= op2_mag;
            q_neg_q    <= op1_neg ^ op2_neg;
            r_neg_q    <= op1_neg;
            div_zero_q <= (bus.issue_op2 == '0);
            div_ovf_q  <= iss_s1 && iss_s2 && (bus.issue_op1 == INT_MIN) && (bus.issue_op2 == '1);
        end else if (state_q == ST_MUL) begin
            acc_q   <= acc_sum;
            mcand_q <= mcand_q << 2;
            mq_q    <= mq_q >> 2;
            if (cnt_q == MUL_LAST) res_q <= mul_res;
        end else if (state_q == ST_DIV) begin
            if (div_special || (cnt_q == DIV_LAST)) begin
                res_q <= div_res;
            end else if (!r_diff[XLEN]) begin
                dr_q <= r_diff[XLEN-1:0];
                dq_q <= {dq_q[XLEN-2:0], 1'b1};
            end else begin
                dr_q <= r_shift[XLEN-1:0];
                dq_q <= {dq_q[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a spec-level arithmetic model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN    = 32;
    localparam int ROBID_W = 7;
    localparam int RD_W    = 6;
    localparam int EW      = ROBID_W + RD_W + XLEN;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    int                 cyc = 0;
    int                 n_pass = 0;
    int                 n_total = 0;
    logic [EW-1:0]      exp_q[$];
    int                 due_q[$];
    logic               head_seen = 1'b0;
    logic [ROBID_W-1:0] tag = '0;

    vec_t vecs [0:22] = '{
        '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 17},
        '{3'd3, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 17},
        '{3'd2, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 17},
        '{3'd0, 32'h0001_2345, 32'h0000_0010, 32'h0012_3450, 17},
        '{3'd0, 32'hffff_fffd, 32'h0000_0005, 32'hffff_fff1, 17},
        '{3'd1, 32'hffff_ffff, 32'h0000_0002, 32'hffff_ffff, 17},
        '{3'd3, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 17},
        '{3'd1, 32'h7fff_ffff, 32'h7fff_ffff, 32'h3fff_ffff, 17},
        '{3'd2, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 17},
        '{3'd4, 32'hffff_fff9, 32'h0000_0002, 32'hffff_fffd, 33},
        '{3'd6, 32'hffff_fff9, 32'h0000_0002, 32'hffff_ffff, 33},
        '{3'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000e, 33},
        '{3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33},
        '{3'd4, 32'h0000_0007, 32'hffff_fffe, 32'hffff_fffd, 33},
        '{3'd6, 32'h0000_0007, 32'hffff_fffe, 32'h0000_0001, 33},
        '{3'd5, 32'hffff_ffff, 32'h0000_0001, 32'hffff_ffff, 33},
        '{3'd4, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 33},
        '{3'd7, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 33},
        '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hffff_ffff, 1},
        '{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1},
        '{3'd4, 32'hffff_ffff, 32'h0000_0000, 32'hffff_ffff, 1},
        '{3'd4, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1},
        '{3'd6, 32'h8000_0000, 32'hffff_ffff, 32'h0000_0000, 1}
    };

    muldiv_if #(.XLEN(XLEN), .ROBID_W(ROBID_W), .RD_W(RD_W)) bus ();

    muldiv_unit #(.XLEN(XLEN), .ROBID_W(ROBID_W), .RD_W(RD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- model ----------------
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hffff_ffff;
                if (ovf)    return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hffff_ffff : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 3'd4) return 17;
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hffff_ffff) return 1;
        return 33;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- scoreboard: one compare process ----------------
    always @(negedge clk) begin
        if (rst || bus.rob_flush) begin
            exp_q.delete();
            due_q.delete();
            head_seen = 1'b0;
        end else begin
            if (bus.wb_valid) begin
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", bus.wb_valid, 1'b0);
                end else begin
                    check("sb_result", bus.wb_result, exp_q[0][XLEN-1:0]);
                    check("sb_rd",     bus.wb_rd,     exp_q[0][XLEN+RD_W-1:XLEN]);
                    check("sb_robid",  bus.wb_robid,  exp_q[0][EW-1:XLEN+RD_W]);
                    if (!head_seen) begin
                        check("sb_latency", cyc, due_q[0]);
                        head_seen = 1'b1;
                    end
                    if (bus.wb_ready) begin
                        void'(exp_q.pop_front());
                        void'(due_q.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
            if (bus.issue_valid && bus.issue_ready) begin
                exp_q.push_back({bus.issue_robid, bus.issue_rd,
                                 model(bus.issue_op, bus.issue_op1, bus.issue_op2)});
                due_q.push_back(cyc + 1 + model_lat(bus.issue_op, bus.issue_op1, bus.issue_op2));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        tag = tag + 1'b1;
        bus.issue_valid = 1'b1;
        bus.issue_op    = op_t'(op);
        bus.issue_op1   = a;
        bus.issue_op2   = b;
        bus.issue_robid = tag;
        bus.issue_rd    = tag[5:0] ^ 6'h2a;
        @(negedge clk);
        while (!bus.issue_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.issue_ready) check("send_ready", bus.issue_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [31:0] exp, input int lat, input int t0);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.wb_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"},  bus.wb_valid, 1'b1);
        check({name, "_lat"},    cyc - t0, lat);
        check({name, "_result"}, bus.wb_result, exp);
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen = seen | bus.wb_valid;
        end
        check(name, seen, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        bus.issue_valid = 1'b0;
        bus.issue_op    = OP_MUL;
        bus.issue_op1   = '0;
        bus.issue_op2   = '0;
        bus.issue_robid = '0;
        bus.issue_rd    = '0;
        bus.wb_ready    = 1'b1;
        bus.rob_flush   = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_wb_valid",    bus.wb_valid,    1'b0);
        check("rst_issue_ready", bus.issue_ready, 1'b1);
        check("rst_state",       bus.dbg_state,   ST_IDLE);
        @(posedge clk);
        #1;

        // Directed vectors with hand-computed results and latencies.
        for (int i = 0; i < 23; i++) begin
            check($sformatf("model_v%0d", i), model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].r);
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            t0 = cyc;
            wait_result($sformatf("vec%0d", i), vecs[i].r, vecs[i].lat, t0);
            @(posedge clk);
            #1;
        end

        // Result held in DONE while writeback stalls, then back-to-back issue.
        bus.wb_ready = 1'b0;
        send(3'd3, 32'h0001_0000, 32'h0003_0000);
        t0 = cyc;
        wait_result("hold", 32'h0000_0003, 17, t0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid",  bus.wb_valid,    1'b1);
            check("hold_result", bus.wb_result,   32'h0000_0003);
            check("hold_robid",  bus.wb_robid,    tag);
            check("hold_ready",  bus.issue_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        bus.wb_ready = 1'b1;
        send(3'd5, 32'd100, 32'd7);
        t0 = cyc;
        @(negedge clk);
        check("b2b_state", bus.dbg_state, ST_DIV);
        wait_result("b2b", 32'd14, 33, t0);
        @(posedge clk);
        #1;

        // Flush in the middle of a divide.
        send(3'd4, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        bus.rob_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.rob_flush = 1'b0;
        @(negedge clk);
        check("flush_wb_valid",    bus.wb_valid,    1'b0);
        check("flush_issue_ready", bus.issue_ready, 1'b1);
        check("flush_state",       bus.dbg_state,   ST_IDLE);
        watch_quiet("flush_no_wb", 40);
        @(posedge clk);
        #1;

        // Reset in the middle of a multiply.
        send(3'd0, 32'd1234, 32'd5678);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_wb_valid",    bus.wb_valid,    1'b0);
        check("rstmid_issue_ready", bus.issue_ready, 1'b1);
        watch_quiet("rstmid_no_wb", 25);
        @(posedge clk);
        #1;

        // Flush and wb_ready together in DONE, with a new request offered.
        bus.wb_ready = 1'b0;
        send(3'd0, 32'd6, 32'd7);
        t0 = cyc;
        wait_result("fdone", 32'd42, 17, t0);
        @(posedge clk);
        #1;
        bus.rob_flush   = 1'b1;
        bus.wb_ready    = 1'b1;
        bus.issue_valid = 1'b1;
        bus.issue_op    = OP_DIVU;
        bus.issue_op1   = 32'd9;
        bus.issue_op2   = 32'd3;
        bus.issue_robid = 7'h7e;
        @(posedge clk);
        #1;
        bus.rob_flush   = 1'b0;
        bus.issue_valid = 1'b0;
        @(negedge clk);
        check("fdone_wb_valid", bus.wb_valid,  1'b0);
        check("fdone_state",    bus.dbg_state, ST_IDLE);
        watch_quiet("fdone_no_wb", 40);

        // A normal op after all the disruptions.
        @(posedge clk);
        #1;
        send(3'd6, 32'hffff_ff9c, 32'd7);
        t0 = cyc;
        wait_result("post", 32'hffff_fffe, 33, t0);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
